stopwatch_lap_ctrl: RTL



---
 rtl/stopwatch_pkg.sv | 27 ++
 rtl/stopwatch_lap_ctrl_btn_edge.sv | 30 +++
 rtl/stopwatch_lap_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Purpose : shared encodings and width helpers for the stopwatch lap/split controller.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package stopwatch_pkg;

    // Display mode encodings as seen on the mode output.
    localparam logic [1:0] MODE_LIVE   = 2'b00;
    localparam logic [1:0] MODE_SPLIT  = 2'b01;
    localparam logic [1:0] MODE_RECALL = 2'b10;

    typedef enum logic [1:0] {
        S_LIVE   = MODE_LIVE,
        S_SPLIT  = MODE_SPLIT,
        S_RECALL = MODE_RECALL
    } mode_t;

    // Width of a lap count that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a ring-buffer pointer addressing depth entries.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_btn_edge.sv
// Purpose : 2-flop synchronizer plus rising-edge detector for one push button.
// Latency : pin sampled high at edge k gives a one-cycle pulse seen by logic at edge k+2.
// Backpressure: none; a pin held high yields exactly one pulse.
// Ports   : clk, rst_n (async active-low), btn (raw pin), pulse (single-cycle event).
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    logic sync_a;
    logic sync_b;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign pulse = sync_b & ~prev;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Purpose : lap/split controller; captures laps into a ring buffer, freezes splits, browses laps.
// Latency : all outputs registered; LIVE display lags time_in by one edge, capture visible at the sampling edge.
// Backpressure: none; button events are consumed or dropped in the cycle they arrive.
// Ports   : clk, rst_n, lap_b, recall_b, run, clr, time_in -> disp_time, disp_lap, lap_cnt, ovf, mode.
// Config  : STOPWATCH_LAP_BTN_SYNC_EN defined = buttons synchronized and edge-detected;
//           undefined = buttons are already synchronous single-cycle pulses.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TIME_W   = 24,
    parameter int DEPTH    = 8,
    parameter int HOLD_CYC = 1000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       lap_b,
    input  logic                       recall_b,
    input  logic                       run,
    input  logic                       clr,
    input  logic [TIME_W-1:0]          time_in,
    output logic [TIME_W-1:0]          disp_time,
    output logic [$clog2(DEPTH+1)-1:0] disp_lap,
    output logic [$clog2(DEPTH+1)-1:0] lap_cnt,
    output logic                       ovf,
    output logic [1:0]                 mode
);

    localparam int CW = cnt_w(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam int TW = $clog2(HOLD_CYC);
    localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);

    logic              lap_ev;
    logic              recall_ev;
    mode_t             state;
    logic [PW-1:0]     wptr;
    logic [TW-1:0]     hold;
    logic [TIME_W-1:0] mem [DEPTH];

    logic              cap;
    logic [CW-1:0]     cnt_nxt;
    logic [CW-1:0]     step_k;
    logic [CW-1:0]     rd_k;
    logic [PW-1:0]     rd_idx;

`ifdef STOPWATCH_LAP_BTN_SYNC_EN
    btn_edge u_lap_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (lap_b),
        .pulse (lap_ev)
    );

    btn_edge u_recall_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (recall_b),
        .pulse (recall_ev)
    );
`else
    assign lap_ev    = lap_b;
    assign recall_ev = recall_b;
`endif

    assign mode = state;

    // A lap only counts while running and outside RECALL; clr cancels it.
    assign cap     = lap_ev & run & (state != S_RECALL) & ~clr;
    assign cnt_nxt = (lap_cnt == FULL) ? FULL : lap_cnt + 1'b1;

    // Single read port: entering RECALL reads the newest lap (k = lap_cnt),
    // stepping reads the lap below the shown one, wrapping 1 -> lap_cnt.
    // Lap k lives at wptr - lap_cnt + k - 1; truncating lap_cnt to PW bits
    // is exact because DEPTH is a power of two.
    always_comb begin
        step_k = (disp_lap == CW'(1)) ? lap_cnt : disp_lap - 1'b1;
        rd_k   = (state == S_RECALL) ? step_k : lap_cnt;
        rd_idx = wptr - lap_cnt[PW-1:0] + rd_k[PW-1:0] - PW'(1);
    end

    // Lap storage has no reset; entries are only read when lap_cnt covers them.
    always_ff @(posedge clk) begin
        if (cap) begin
            mem[wptr] <= time_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LIVE;
            disp_time <= '0;
            disp_lap  <= '0;
            lap_cnt   <= '0;
            ovf       <= 1'b0;
            wptr      <= '0;
            hold      <= '0;
        end else if (clr) begin
            state     <= S_LIVE;
            disp_time <= time_in;
            disp_lap  <= '0;
            lap_cnt   <= '0;
            ovf       <= 1'b0;
            wptr      <= '0;
            hold      <= '0;
        end else if (cap) begin
            // Covers both the first capture from LIVE and a re-capture in SPLIT.
            state     <= S_SPLIT;
            disp_time <= time_in;
            disp_lap  <= cnt_nxt;
            lap_cnt   <= cnt_nxt;
            wptr      <= wptr + 1'b1;
            hold      <= HOLD_LD;
            if (lap_cnt == FULL) begin
                ovf <= 1'b1;
            end
        end else begin
            case (state)
                S_LIVE: begin
                    // Any lap pulse, even an ignored one, suppresses recall.
                    if (recall_ev && !lap_ev && !run && lap_cnt != '0) begin
                        state     <= S_RECALL;
                        disp_lap  <= lap_cnt;
                        disp_time <= mem[rd_idx];
                    end else begin
                        disp_time <= time_in;
                    end
                end
                S_SPLIT: begin
                    if (hold == '0) begin
                        state     <= S_LIVE;
                        disp_lap  <= '0;
                        disp_time <= time_in;
                    end else begin
                        hold <= hold - 1'b1;
                    end
                end
                S_RECALL: begin
                    if (lap_ev || run) begin
                        state     <= S_LIVE;
                        disp_lap  <= '0;
                        disp_time <= time_in;
                    end else if (recall_ev) begin
                        disp_lap  <= step_k;
                        disp_time <= mem[rd_idx];
                    end
                end
                default: begin
                    state <= S_LIVE;
                end
            endcase
        end
    end

endmodule
